// File: rtl/dma_controller_pkg.sv
// Shared types and bus constants for the memory-to-memory DMA master.
// Word-aligned addressing helpers live here so the FSM and any sub-blocks agree.
package dma_controller_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int COUNT_W = 16;
    localparam int TMR_W   = 8;

    localparam logic [3:0]        MASK_WORD  = 4'b1111;
    localparam logic [ADDR_W-1:0] WORD_BYTES = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_RD_END,
        ST_WR,
        ST_WR_END,
        ST_REL,
        ST_FIN
    } dma_state_t;

    // Byte addresses are forced onto a word boundary; the low two bits are don't-care.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~(WORD_BYTES - 32'd1);
    endfunction

    function automatic logic is_bus_phase(input dma_state_t s);
        return (s == ST_RD) || (s == ST_RD_END) || (s == ST_WR) || (s == ST_WR_END);
    endfunction

endpackage

// File: rtl/dma_controller_timeout.sv
// Strobe watchdog: down-counter reloaded on clr, decremented on en, expired at terminal count.
// A load of TIMEOUT-1 makes expiry coincide with the TIMEOUT-th cycle of an unanswered strobe.
module dma_controller_timeout
    import dma_controller_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [TMR_W-1:0] LOAD = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= LOAD;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/dma_controller.sv
// Memory-to-memory DMA bus master: copies word_count 32-bit words from src to dst,
// owning the shared tri-state bus only while granted and releasing it every BURST_LEN words.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; zero-length jobs finish here
// REQ       | dma_req high, waiting for dma_grant
// RD        | read strobe at src, waiting for fc_bus
// RD_END    | strobes low, waiting for fc_bus to drop
// WR        | write strobe at dst with buffered data, waiting for fc_bus
// WR_END    | strobes low, waiting for fc_bus to drop; pick next step
// REL       | dma_req low for one cycle so the CPU can win arbitration
// FIN       | done pulse (error valid), then back to IDLE
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               dma_req,
    input  logic               dma_grant,
    inout  wire  [ADDR_W-1:0]  addr_bus,
    inout  wire  [DATA_W-1:0]  data_bus,
    inout  wire                wr_bus,
    inout  wire                rd_bus,
    inout  wire  [3:0]         data_mask_bus,
    input  logic               fc_bus
);

    localparam int BURST_W = $clog2(BURST_LEN + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN);

    dma_state_t          state;
    logic [ADDR_W-1:0]   src;
    logic [ADDR_W-1:0]   dst;
    logic [COUNT_W-1:0]  remaining;
    logic [BURST_W-1:0]  burst_cnt;
    logic [DATA_W-1:0]   buffer;

    logic                owned;
    logic                strobing;
    logic                tmr_en;
    logic                tmr_clr;
    logic                tmr_expired;
    logic [ADDR_W-1:0]   addr_drv;

    assign owned    = dma_grant && is_bus_phase(state);
    assign strobing = dma_grant && ((state == ST_RD) || (state == ST_WR));

    // Watchdog only runs while a strobe is actually on the bus; any other cycle reloads it.
    assign tmr_en  = strobing && !fc_bus;
    assign tmr_clr = !strobing;

    dma_controller_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            dma_req   <= 1'b0;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            burst_cnt <= '0;
            buffer    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (word_count != '0) begin
                            src       <= word_align(src_addr);
                            dst       <= word_align(dst_addr);
                            remaining <= word_count;
                            burst_cnt <= '0;
                            busy      <= 1'b1;
                            dma_req   <= 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (dma_grant) begin
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (dma_grant && fc_bus) begin
                        buffer <= data_bus;
                        state  <= ST_RD_END;
                    end else if (dma_grant && tmr_expired) begin
                        error   <= 1'b1;
                        dma_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_FIN;
                    end
                end
                ST_RD_END: begin
                    if (!fc_bus) begin
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (dma_grant && fc_bus) begin
                        remaining <= remaining - 1'b1;
                        src       <= src + WORD_BYTES;
                        dst       <= dst + WORD_BYTES;
                        burst_cnt <= burst_cnt + 1'b1;
                        state     <= ST_WR_END;
                    end else if (dma_grant && tmr_expired) begin
                        error   <= 1'b1;
                        dma_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_FIN;
                    end
                end
                ST_WR_END: begin
                    if (!fc_bus) begin
                        if (remaining == '0) begin
                            dma_req <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_FIN;
                        end else if (burst_cnt == BURST_LAST) begin
                            burst_cnt <= '0;
                            dma_req   <= 1'b0;
                            state     <= ST_REL;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_REL: begin
                    dma_req <= 1'b1;
                    state   <= ST_REQ;
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read phases present the source address, write phases the destination.
    assign addr_drv = ((state == ST_WR) || (state == ST_WR_END)) ? dst : src;

    assign addr_bus      = owned ? addr_drv : 'z;
    assign data_bus      = (owned && (state == ST_WR)) ? buffer : 'z;
    assign rd_bus        = owned ? (state == ST_RD) : 1'bz;
    assign wr_bus        = owned ? (state == ST_WR) : 1'bz;
    assign data_mask_bus = owned ? MASK_WORD : 4'bzzzz;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: a behavioural bus slave and arbitrator drive the DUT,
// and each job's bus traffic is compared against the word-by-word copy the job should perform.
module tb_dma_controller;
    import dma_controller_pkg::*;

    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        error;
    logic        dma_req;
    logic        dma_grant  = 1'b0;
    logic        fc_bus     = 1'b0;
    logic        slave_drv  = 1'b0;
    logic [31:0] slave_data = 32'd0;

    wire  [31:0] addr_bus;
    wire  [31:0] data_bus;
    tri0         wr_bus;
    tri0         rd_bus;
    tri0  [3:0]  data_mask_bus;

    assign data_bus = slave_drv ? slave_data : 'z;

    always #5 clk = ~clk;

    dma_controller #(
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .dma_req       (dma_req),
        .dma_grant     (dma_grant),
        .addr_bus      (addr_bus),
        .data_bus      (data_bus),
        .wr_bus        (wr_bus),
        .rd_bus        (rd_bus),
        .data_mask_bus (data_mask_bus),
        .fc_bus        (fc_bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // bus environment knobs (set by the main sequence)
    int hold_on_rel    = 0;
    int stall_read_idx = -1;
    int rand_dly       = 0;
    int drop_pct       = 0;

    // observations
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          rel_runs[$];
    int          done_cnt    = 0;
    int          done_cyc    = -1;
    int          stall_cyc   = -1;
    int          req_cycles  = 0;
    logic        req_at_done = 1'b0;

    int   cyc        = 0;
    int   strobe_age = 0;
    int   fc_dly     = 0;
    int   hold_cnt   = 0;
    int   low_run    = 0;
    logic prev_req   = 1'b0;
    logic owned_obs;

    // Slave + arbitrator: everything reacts on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            fc_bus     = 1'b0;
            slave_drv  = 1'b0;
            dma_grant  = 1'b0;
            strobe_age = 0;
            hold_cnt   = 0;
            low_run    = 0;
            prev_req   = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = cyc;
                    req_at_done = dma_req;
                end
            end
            if (dma_req) req_cycles++;
            if (dma_req && !prev_req && low_run > 0) rel_runs.push_back(low_run);
            if (!busy || dma_req) low_run = 0;
            else low_run++;
            if (hold_on_rel != 0 && prev_req && !dma_req && busy) hold_cnt = 6;
            if (hold_cnt > 0) begin
                check_eq("hold_bus_released", {28'd0, data_mask_bus}, 32'd0);
                hold_cnt--;
            end
            prev_req  = dma_req;

            owned_obs = (data_mask_bus === 4'hF);
            if (fc_bus) begin
                if (!(owned_obs && (rd_bus || wr_bus))) begin
                    fc_bus    = 1'b0;
                    slave_drv = 1'b0;
                end
            end else if (owned_obs && (rd_bus ^ wr_bus)) begin
                if (rd_bus && rd_log.size() == stall_read_idx) begin
                    if (stall_cyc < 0) stall_cyc = cyc;
                end else if (strobe_age >= fc_dly) begin
                    fc_bus     = 1'b1;
                    strobe_age = 0;
                    fc_dly     = (rand_dly != 0) ? int'($urandom_range(0, 2)) : 0;
                    if (rd_bus) begin
                        rd_log.push_back(addr_bus);
                        slave_data = mem_word(addr_bus);
                        slave_drv  = 1'b1;
                    end else begin
                        wr_addr_log.push_back(addr_bus);
                        wr_data_log.push_back(data_bus);
                    end
                end else begin
                    strobe_age++;
                end
            end
            if (!fc_bus)
                dma_grant = dma_req && (hold_cnt == 0) &&
                            !(drop_pct > 0 && int'($urandom_range(0, 99)) < drop_pct);
        end
    end

    task automatic clear_logs();
        #1;
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        rel_runs.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        stall_cyc  = -1;
        req_cycles = 0;
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr   = s;
        dst_addr   = d;
        word_count = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_finished_in_budget"}, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Expected traffic is derived purely from the job request: word i moves from
    // align(s)+4i to align(d)+4i (mod 2^32), and the bus is released once per full burst.
    task automatic verify_job(input string tag, input logic [31:0] s, input logic [31:0] d,
                              input int nrd, input int nwr, input logic exp_err, input int exp_rels);
        logic [31:0] sa;
        logic [31:0] da;
        check_eq({tag, "_done_pulses"}, done_cnt, 32'd1);
        check_eq({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check_eq({tag, "_reads"}, rd_log.size(), nrd);
        check_eq({tag, "_writes"}, wr_addr_log.size(), nwr);
        check_eq({tag, "_releases"}, rel_runs.size(), exp_rels);
        for (int i = 0; i < rel_runs.size(); i++)
            check_eq($sformatf("%s_rel%0d_len", tag, i), rel_runs[i], 32'd1);
        for (int i = 0; i < nrd && i < rd_log.size(); i++) begin
            sa = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            check_eq($sformatf("%s_rd%0d_addr", tag, i), rd_log[i], sa);
        end
        for (int i = 0; i < nwr && i < wr_addr_log.size(); i++) begin
            sa = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            da = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            check_eq($sformatf("%s_wr%0d_addr", tag, i), wr_addr_log[i], da);
            check_eq($sformatf("%s_wr%0d_data", tag, i), wr_data_log[i], mem_word(sa));
        end
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] rd;
        int          rn;
        int          n;

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_error", {31'd0, error}, 32'd0);
        check_eq("rst_req", {31'd0, dma_req}, 32'd0);
        check_eq("rst_bus_released", {28'd0, data_mask_bus}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic three-word copy, fc one cycle after each strobe
        clear_logs();
        start_job(32'h100, 32'h200, 16'd3);
        check_eq("basic_busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle("basic", 500);
        verify_job("basic", 32'h100, 32'h200, 3, 3, 1'b0, 0);

        // zero-length job
        clear_logs();
        start_job(32'h40, 32'h80, 16'd0);
        check_eq("zero_done", {31'd0, done}, 32'd1);
        check_eq("zero_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("zero_done_pulse_width", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("zero_req_cycles", req_cycles, 32'd0);
        check_eq("zero_done_count", done_cnt, 32'd1);

        // burst release with the CPU holding the bus after each release
        clear_logs();
        hold_on_rel = 1;
        start_job(32'h1000, 32'h8000, 16'd10);
        wait_idle("burst", 2000);
        verify_job("burst", 32'h1000, 32'h8000, 10, 10, 1'b0, 2);
        hold_on_rel = 0;

        // second read never acknowledged -> timeout abort
        clear_logs();
        stall_read_idx = 1;
        start_job(32'h2000, 32'h3000, 16'd4);
        wait_idle("tmo", 1000);
        verify_job("tmo", 32'h2000, 32'h3000, 1, 1, 1'b1, 0);
        check_eq("tmo_cycles", done_cyc - stall_cyc, 32'd255);
        check_eq("tmo_req_at_done", {31'd0, req_at_done}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("tmo_error_held", {31'd0, error}, 32'd1);
        stall_read_idx = -1;

        // address wrap, plus a start while busy that must be ignored
        clear_logs();
        start_job(32'hFFFF_FFFE, 32'h300, 16'd2);
        src_addr = 32'h5000; dst_addr = 32'h6000; word_count = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("wrap", 500);
        repeat (4) @(negedge clk);
        check_eq("wrap_busy_stays_low", {31'd0, busy}, 32'd0);
        verify_job("wrap", 32'hFFFF_FFFC, 32'h300, 2, 2, 1'b0, 0);
        if (rd_log.size() > 1) check_eq("wrap_second_read", rd_log[1], 32'h0000_0000);

        // asynchronous reset in the middle of an 8-word job
        clear_logs();
        start_job(32'h4000, 32'h4800, 16'd8);
        n = 0;
        while (data_mask_bus !== 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("midrst_bus_owned", {28'd0, data_mask_bus}, 32'hF);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_req", {31'd0, dma_req}, 32'd0);
        check_eq("midrst_bus_released", {28'd0, data_mask_bus}, 32'd0);
        check_eq("midrst_strobes", {30'd0, rd_bus, wr_bus}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("midrst_no_done", done_cnt, 32'd0);
        check_eq("midrst_idle", {30'd0, busy, dma_req}, 32'd0);
        check_eq("midrst_error", {31'd0, error}, 32'd0);

        // randomized jobs with variable slave latency and grant loss
        rand_dly = 1;
        drop_pct = 15;
        for (int j = 0; j < 6; j++) begin
            rs = $urandom;
            rd = $urandom;
            rn = int'($urandom_range(1, 12));
            clear_logs();
            start_job(rs, rd, 16'(rn));
            wait_idle($sformatf("rnd%0d", j), 3000);
            verify_job($sformatf("rnd%0d", j), rs, rd, rn, rn, 1'b0, (rn - 1) / BURST_LEN);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
